// File: rtl/turn_signal_pkg.sv
// Shared types and widths for the turn-signal sequencer.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  localparam int unsigned TICK_W = 8;
  localparam int unsigned CMF_W  = 4;

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// Driver-controls / lamp-request bundle between the controls and turn_signal_ctrl.
interface turn_signal_ctrl_if;
  logic lever_left;
  logic lever_right;
  logic hazard_btn;
  logic left;
  logic right;
  logic E;
  logic tick;
  logic active;

  modport master (
    output lever_left, lever_right, hazard_btn,
    input  left, right, E, tick, active
  );

  modport slave (
    input  lever_left, lever_right, hazard_btn,
    output left, right, E, tick, active
  );
endinterface

// File: rtl/turn_signal_ctrl_tick_gen.sv
// Blink-step divider: one-cycle tick every TICK_DIV cycles while enabled.
module tick_gen
  import turn_signal_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [TICK_W-1:0] CNT_TOP = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en)
      cnt <= '0;
    else if (cnt == CNT_TOP)
      cnt <= '0;
    else
      cnt <= cnt + TICK_W'(1);
  end

  assign tick = en & (cnt == CNT_TOP);

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn/hazard request sequencer for the tail-light lamp block.
// Optional comfort blink (hold after a short lever tap) enabled by `COMFORT_BLINK_EN.
module turn_signal_ctrl
  import turn_signal_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 10,
  parameter int unsigned COMFORT_TICKS = 3
) (
  input logic               clk,
  input logic               rst,
  turn_signal_ctrl_if.slave bus
);

  if (TICK_DIV < 2 || TICK_DIV > 255 || COMFORT_TICKS < 1 || COMFORT_TICKS > 15) begin : g_param_check
    $error("turn_signal_ctrl: TICK_DIV or COMFORT_TICKS out of range");
  end

  state_t state, state_nxt;
  logic   hzd_prev, hzd_latch, hzd_rise, latch_nxt;
  logic   tick, active, clr, hold;
  logic   left_q, right_q, e_q;

  assign hzd_rise  = bus.hazard_btn & ~hzd_prev;
  assign latch_nxt = hzd_latch ^ hzd_rise;

`ifdef COMFORT_BLINK_EN
  localparam logic [CMF_W-1:0] CMF_LOAD = CMF_W'(COMFORT_TICKS);

  logic [CMF_W-1:0] cmf, cmf_dec, cmf_nxt;

  // Decrement is applied before the hold decision so the last tick exits on its own edge.
  assign cmf_dec = (tick && cmf != '0) ? cmf - CMF_W'(1) : cmf;
  assign hold    = (state == LEFT || state == RIGHT) && (cmf_dec != '0);

  always_comb begin
    cmf_nxt = cmf_dec;
    if ((state_nxt == LEFT || state_nxt == RIGHT) && state_nxt != state)
      cmf_nxt = CMF_LOAD;
    else if (state_nxt == HAZARD || state_nxt == IDLE)
      cmf_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cmf <= '0;
    else
      cmf <= cmf_nxt;
  end
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hzd_latch <= 1'b0;
      // Tracks the button through reset so a button held across reset is not a new press.
      hzd_prev  <= bus.hazard_btn;
    end else begin
      state     <= state_nxt;
      hzd_latch <= latch_nxt;
      hzd_prev  <= bus.hazard_btn;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    left_q    = 1'b0;
    right_q   = 1'b0;
    e_q       = 1'b0;

    if (latch_nxt)
      state_nxt = HAZARD;
    else if (bus.lever_left && bus.lever_right)
      state_nxt = IDLE;
    else if (bus.lever_left)
      state_nxt = LEFT;
    else if (bus.lever_right)
      state_nxt = RIGHT;
    else if (hold)
      state_nxt = state;

    unique case (state)
      LEFT:    left_q  = 1'b1;
      RIGHT:   right_q = 1'b1;
      HAZARD:  e_q     = 1'b1;
      default: ;
    endcase
  end

  assign active = (state != IDLE);
  assign clr    = (state_nxt != state);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (active),
    .tick(tick)
  );

  assign bus.left   = left_q;
  assign bus.right  = right_q;
  assign bus.E      = e_q;
  assign bus.tick   = tick;
  assign bus.active = active;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed self-checking bench for turn_signal_ctrl (TICK_DIV=10, COMFORT_TICKS=3).
module tb_turn_signal_ctrl;

  logic clk = 1'b0;
  logic rst;
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  turn_signal_ctrl_if bus ();

  turn_signal_ctrl #(
    .TICK_DIV     (10),
    .COMFORT_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Expected vector order: {left, right, E, tick, active}
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.left, bus.right, bus.E, bus.tick, bus.active};
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed {l,r,E,tick,act}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ll, input logic lr, input logic hb);
    bus.lever_left  = ll;
    bus.lever_right = lr;
    bus.hazard_btn  = hb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with every input high
    rst = 1'b1;
    drive(1, 1, 1);
    @(negedge clk); check("rst_c1", 5'b00000);
    @(negedge clk); check("rst_c2", 5'b00000);
    rst = 1'b0;
    drive(0, 0, 0);
    @(negedge clk); check("idle_after_rst", 5'b00000);

    // 2. Left turn held 40 cycles, tick at offsets 9/19/29/39
    drive(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("turn_i%0d", i), (i % 10 == 9) ? 5'b10011 : 5'b10001);
    end
    drive(0, 0, 0);
    @(negedge clk); check("turn_release", 5'b00000);

    // 3. Conflict then single lever
    drive(1, 0, 0);
    @(negedge clk); check("conf_left", 5'b10001);
    drive(1, 1, 0);
    @(negedge clk); check("conf_both", 5'b00000);
    drive(0, 1, 0);
    @(negedge clk); check("conf_right", 5'b01001);

    // 4. Direct RIGHT->LEFT switch, then hazard over turn
    drive(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check($sformatf("switch_left_i%0d", i), 5'b10001);
    end
    drive(1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check($sformatf("hzd_hold_i%0d", i), 5'b00101);
    end
    drive(1, 0, 0);
    @(negedge clk); check("hzd_btn_up", 5'b00101);
    drive(1, 0, 1);
    @(negedge clk); check("hzd_off_left", 5'b10001);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hzd_off_tick_i%0d", i), (i == 9) ? 5'b10011 : 5'b10001);
    end
    drive(1, 1, 0);
    @(negedge clk); check("end4_conflict", 5'b00000);
    drive(0, 0, 0);
    @(negedge clk); check("end4_idle", 5'b00000);

    // 6. Reset mid-hazard with button held
    drive(0, 0, 1);
    @(negedge clk); check("rh_enter", 5'b00101);
    rst = 1'b1;
    @(negedge clk); check("rh_reset", 5'b00000);
    rst = 1'b0;
    @(negedge clk); check("rh_held1", 5'b00000);
    @(negedge clk); check("rh_held2", 5'b00000);
    drive(0, 0, 0);
    @(negedge clk); check("rh_btn_up", 5'b00000);
    drive(0, 0, 1);
    @(negedge clk); check("rh_repress", 5'b00101);
    drive(0, 0, 0);
    @(negedge clk); check("rh_hold", 5'b00101);
    drive(0, 0, 1);
    @(negedge clk); check("rh_exit", 5'b00000);
    drive(0, 0, 0);
    @(negedge clk); check("rh_idle", 5'b00000);

`ifdef COMFORT_BLINK_EN
    // 5a. One-cycle tap keeps LEFT through the third tick
    drive(1, 0, 0);
    @(negedge clk); check("cmf_tap", 5'b10001);
    drive(0, 0, 0);
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("cmf_hold_i%0d", i), (i % 10 == 9) ? 5'b10011 : 5'b10001);
    end
    @(negedge clk); check("cmf_exit", 5'b00000);

    // 5b. Right tap at k+15 switches and reloads the hold
    drive(1, 0, 0);
    @(negedge clk); check("cmf2_tap", 5'b10001);
    drive(0, 0, 0);
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      check($sformatf("cmf2_left_i%0d", i), (i == 9) ? 5'b10011 : 5'b10001);
    end
    drive(0, 1, 0);
    @(negedge clk); check("cmf2_switch", 5'b01001);
    drive(0, 0, 0);
    for (int j = 1; j < 30; j++) begin
      @(negedge clk);
      check($sformatf("cmf2_right_j%0d", j), (j % 10 == 9) ? 5'b01011 : 5'b01001);
    end
    @(negedge clk); check("cmf2_exit", 5'b00000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
